sum_accum16s: RTL and testbench

//  Downstream stage of the sequential 16-bit adder: consumes its {cout,sum} result

---
 rtl/sum_accum16s_pkg.sv | 14 +
 rtl/sum_accum16s_acc_add.sv | 50 +++++
 rtl/sum_accum16s.sv | 99 +++++++++
 tb/tb_sum_accum16s.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum16s_pkg.sv
// Shared types and defaults for the adder16s result accumulator.
package sum_accum16s_pkg;

  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned OPND_W    = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accum16s_acc_add.sv
// Accumulator register with wrap-around add and sticky carry-out flag.
module sum_accum16s_acc_add
  import sum_accum16s_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [OPND_W-1:0] opnd_i,
  output logic [ACC_W-1:0]  total_o,
  output logic              ovf_o
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] total_q, total_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum_c;

  // Extra top bit of the sum is the carry out of the accumulator.
  assign sum_c = SUM_W'(total_q) + SUM_W'(opnd_i);

  always_comb begin
    total_d = total_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      total_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      total_d = sum_c[ACC_W-1:0];
      ovf_d   = ovf_q | sum_c[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

  assign total_o = total_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/sum_accum16s.sv
// Accumulates a block of len {cout,sum} results from adder16s and hands the
// total downstream under a valid/ready handshake.
module sum_accum16s
  import sum_accum16s_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      sum,
  input  logic             cout,
  output logic             in_ready,
  output logic [ACC_W-1:0] total,
  output logic [LEN_W-1:0] count,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             clr_c;
  logic             accept_c;
  logic             last_c;

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);

  assign accept_c = in_valid & in_ready;
  assign last_c   = (count_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    clr_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_c   = 1'b1;
          state_d = (len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (accept_c && last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    count_d = count_q;
    if (clr_c) begin
      len_d   = len;
      count_d = '0;
    end else if (accept_c) begin
      count_d = count_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  sum_accum16s_acc_add #(
    .ACC_W(ACC_W)
  ) u_acc_add (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (clr_c),
    .en_i   (accept_c),
    .opnd_i ({cout, sum}),
    .total_o(total),
    .ovf_o  (ovf)
  );

  assign count = count_q;

endmodule

// File: tb/tb_sum_accum16s.sv
// Self-checking bench for sum_accum16s: table of blocks plus reset sequences.
module tb_sum_accum16s;

  localparam int unsigned ACC_W = 24;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [15:0]      sum = '0;
  logic             cout = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] total;
  logic [LEN_W-1:0] count;
  logic             ovf;
  logic             out_valid;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  sum_accum16s #(
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .in_ready (in_ready),
    .total    (total),
    .count    (count),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0]  len;
    logic [16:0] base;
    logic [16:0] step;
    int          gap;
    int          hold;
    logic [23:0] exp_total;
    logic [7:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [23:0] total;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, "_total"}, 32'(total), 32'(e.total));
    check({tag, "_count"}, 32'(count), 32'(e.count));
    check({tag, "_ovf"},   32'(ovf),   32'(e.ovf));
  endtask

  task automatic score_pop(output exp_t e);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got output with no expected entry at %0t", $time);
      e.total = '0;
      e.count = '0;
      e.ovf   = 1'b0;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic run_block(input vec_t v);
    exp_t        e;
    exp_t        got;
    logic [16:0] item;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    len   = v.len;
    e.total = v.exp_total;
    e.count = v.exp_count;
    e.ovf   = v.exp_ovf;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    len   = 8'($urandom);
    item  = v.base;
    for (int k = 0; k < int'(v.len); k++) begin
      if (k > 0) begin
        repeat (v.gap) begin
          in_valid = 1'b0;
          sum      = 16'($urandom);
          cout     = 1'b0;
          check("gap_in_ready", 32'(in_ready), 32'd1);
          @(negedge clk);
        end
      end
      check("acc_in_ready", 32'(in_ready), 32'd1);
      check("no_early_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      sum      = item[15:0];
      cout     = item[16];
      item     = item + v.step;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    score_pop(got);
    check_outputs("result", got);
    // Stall the consumer while poking start/in_valid: nothing may move.
    repeat (v.hold) begin
      out_ready = 1'b0;
      start     = 1'b1;
      in_valid  = 1'b1;
      sum       = 16'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check_outputs("hold", got);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd0);
    check_outputs("post", got);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t one;
    vecs[0] = '{8'd3,   17'd100,     17'd100, 0, 0, 24'd600,     8'd3,   1'b0};
    vecs[1] = '{8'd2,   17'h1FFFF,   17'd2,   2, 3, 24'h020000,  8'd2,   1'b0};
    vecs[2] = '{8'd0,   17'd0,       17'd0,   0, 2, 24'd0,       8'd0,   1'b0};
    vecs[3] = '{8'd255, 17'h1FFFF,   17'd0,   0, 1, 24'hFDFF01,  8'd255, 1'b1};
    vecs[4] = '{8'd3,   17'd100,     17'd100, 1, 1, 24'd600,     8'd3,   1'b0};
    vecs[5] = '{8'd128, 17'h1FFFF,   17'd0,   0, 0, 24'hFFFF80,  8'd128, 1'b0};
    vecs[6] = '{8'd129, 17'h1FFFF,   17'd0,   0, 0, 24'h01FF7F,  8'd129, 1'b1};
    vecs[7] = '{8'd4,   17'h10000,   17'd1,   3, 0, 24'h040006,  8'd4,   1'b0};

    #20;
    check("rst_total",     32'(total),     32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_block(vecs[i]);

    // Reset in the middle of a block discards it entirely.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      sum      = 16'd1000;
      cout     = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midop_count", 32'(count), 32'd2);
    check("midop_total", 32'(total), 32'd2000);
    reset = 1'b0;
    #1;
    check("midrst_total",     32'(total),     32'd0);
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_ovf",       32'(ovf),       32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    one = '{8'd1, 17'd5, 17'd0, 0, 1, 24'd5, 8'd1, 1'b0};
    run_block(one);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
